uart_fifo_tx: RTL and testbench

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_baud_gen.sv | 16 +
 rtl/uart_fifo_tx.sv | 92 +++++++++
 tb/tb_uart_fifo_tx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings, transmitter state encoding and bit-period helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with one-cycle tick on its last count
module uart_baud_gen #(
  parameter int CPB = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CPB);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CPB - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: FIFO-fed UART transmitter, back-to-back frames with no idle gap
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_do,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IW  = $clog2(DATA_BITS);
  state_t state, state_d;
  logic [DATA_BITS-1:0] sh, sh_d;
  logic [IW-1:0] idx, idx_d;
  logic par, par_d, tx_d, tick, fetch, last_data, last_stop;
  uart_baud_gen #(.CPB(CPB)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .restart(state == IDLE),
    .tick(tick)
  );
  assign last_data = idx == IW'(DATA_BITS - 1);
  assign last_stop = idx == IW'(STOP_BITS - 1);
  assign done      = state == STOP && tick && last_stop;
  // rst_n gate keeps the pop strobe quiet while reset is held
  assign fetch     = rst_n && en && !fifo_empty && (state == IDLE || done);
  assign fifo_rd   = fetch;
  assign busy      = fetch || state != IDLE;
  // tx is computed one cycle ahead so the line comes straight from a flop
  always_comb begin
    state_d = state;
    sh_d    = sh;
    idx_d   = idx;
    par_d   = par;
    tx_d    = tx;
    if (fetch) begin
      state_d = START;
      sh_d    = fifo_do;
      par_d   = (^fifo_do) ^ (PARITY == PAR_ODD);
      idx_d   = '0;
      tx_d    = 1'b0;
    end else if (tick) begin
      case (state)
        START: begin
          state_d = DATA;
          tx_d    = sh[0];
        end
        DATA: begin
          sh_d    = sh >> 1;
          idx_d   = last_data ? '0 : idx + IW'(1);
          state_d = last_data ? (PARITY == PAR_NONE ? STOP : PAR) : DATA;
          tx_d    = last_data ? (PARITY == PAR_NONE ? 1'b1 : par) : sh[1];
        end
        PAR: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: begin
          idx_d   = last_stop ? '0 : idx + IW'(1);
          state_d = last_stop ? IDLE : STOP;
          tx_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      idx   <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      sh    <= sh_d;
      idx   <= idx_d;
      par   <= par_d;
      tx    <= tx_d;
    end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: directed frames on four parameter variants, 10 clocks per bit
module tb_uart_fifo_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] en_v = '0, emp_v = '1, tx_v, rd_v, busy_v, done_v;
  logic [7:0] do_v [4];
  logic wave [0:255];
  logic bwave [0:255];
  int errors = 0, checks = 0;
  int done_cnt, done_at, rd_cnt, rd_at;
  always #5 clk = ~clk;
  uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .fifo_empty(emp_v[0]), .fifo_do(do_v[0]),
    .fifo_rd(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .fifo_empty(emp_v[1]), .fifo_do(do_v[1]),
    .fifo_rd(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .fifo_empty(emp_v[2]), .fifo_do(do_v[2]),
    .fifo_rd(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_fifo_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en_v[3]), .fifo_empty(emp_v[3]), .fifo_do(do_v[3]),
    .fifo_rd(rd_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_rd(input int k, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = rd_v[k];
    end
    chk({tag, " fifo_rd seen"}, {31'b0, ok}, 32'd1);
  endtask
  // starts at the negedge of the fetch cycle; cycle 1 is the first frame cycle
  task automatic record(input int k, input int n, input logic [7:0] new_do, input int en_off, input int emp_off);
    done_cnt = 0; done_at = 0; rd_cnt = 0; rd_at = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) do_v[k] = new_do;
      if (i == en_off) en_v[k] = 1'b0;
      if (i == emp_off) emp_v[k] = 1'b1;
      @(negedge clk);
      wave[i] = tx_v[k];
      bwave[i] = busy_v[k];
      if (done_v[k]) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
      if (rd_v[k]) begin
        rd_cnt++;
        if (rd_at == 0) rd_at = i;
      end
    end
  endtask
  task automatic chk_bits(input int nb, input logic [23:0] exp, input string tag);
    logic obs;
    for (int j = 0; j < nb; j++) begin
      obs = wave[1 + j * 10];
      for (int c = 1; c < 10; c++) if (wave[1 + j * 10 + c] !== obs) obs = 1'bx;
      chk($sformatf("%s bit%0d", tag, j), {31'b0, obs}, {31'b0, exp[j]});
    end
  endtask
  task automatic chk_high(input int from, input int to, input string tag);
    int ones = 0;
    for (int i = from; i <= to; i++) if (wave[i] === 1'b1) ones++;
    chk(tag, ones, to - from + 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4; i++) do_v[i] = 8'h00;
    en_v[0] = 1'b1; emp_v[0] = 1'b0; do_v[0] = 8'h55;
    repeat (3) @(negedge clk);
    chk("reset tx", {28'b0, tx_v}, 32'hF);
    chk("reset busy", {28'b0, busy_v}, 32'h0);
    chk("reset done", {28'b0, done_v}, 32'h0);
    chk("reset fifo_rd", {28'b0, rd_v}, 32'h0);
    en_v[0] = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    // en low with data waiting: nothing may be fetched
    rd_cnt = 0; done_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      wave[i] = tx_v[0];
      if (rd_v[0]) rd_cnt++;
    end
    chk("en0 fifo_rd count", rd_cnt, 0);
    chk_high(1, 30, "en0 tx high");
    en_v[0] = 1'b1;
    wait_rd(0, "0x55");
    chk("0x55 tx in fetch cycle", {31'b0, tx_v[0]}, 32'd1);
    chk("0x55 busy in fetch cycle", {31'b0, busy_v[0]}, 32'd1);
    record(0, 110, 8'hAA, 1, 1);
    chk_bits(10, 24'b1_01010101_0, "0x55");
    chk("0x55 done cycle", done_at, 100);
    chk("0x55 done count", done_cnt, 1);
    chk("0x55 extra fifo_rd", rd_cnt, 0);
    chk("0x55 busy last stop", {31'b0, bwave[100]}, 32'd1);
    chk("0x55 busy after", {31'b0, bwave[101]}, 32'd0);
    chk_high(101, 110, "0x55 idle high");
    do_v[0] = 8'h0F; emp_v[0] = 1'b0; en_v[0] = 1'b1;
    wait_rd(0, "en drop");
    record(0, 150, 8'h33, 30, 0);
    chk_bits(10, 24'b1_00001111_0, "en drop");
    chk("en drop done cycle", done_at, 100);
    chk("en drop second fifo_rd", rd_cnt, 0);
    chk_high(101, 150, "en drop idle high");
    do_v[0] = 8'hA5; en_v[0] = 1'b1;
    wait_rd(0, "b2b");
    record(0, 205, 8'h3C, 101, 101);
    chk("b2b fifo_rd spacing", rd_at, 100);
    chk("b2b fifo_rd count", rd_cnt, 1);
    chk("b2b done count", done_cnt, 2);
    chk("b2b no idle gap", {31'b0, wave[101]}, 32'd0);
    chk_bits(20, 24'b1_00111100_0_1_10100101_0, "b2b");
    chk_high(201, 205, "b2b idle high");
    do_v[1] = 8'h07; emp_v[1] = 1'b0; en_v[1] = 1'b1;
    wait_rd(1, "even");
    record(1, 120, 8'hF8, 1, 1);
    chk_bits(11, 24'b1_1_00000111_0, "even");
    chk("even done cycle", done_at, 110);
    chk_high(111, 120, "even idle high");
    do_v[2] = 8'h07; emp_v[2] = 1'b0; en_v[2] = 1'b1;
    wait_rd(2, "odd");
    record(2, 120, 8'hF8, 1, 1);
    chk_bits(11, 24'b1_0_00000111_0, "odd");
    chk("odd done cycle", done_at, 110);
    do_v[3] = 8'hFF; emp_v[3] = 1'b0; en_v[3] = 1'b1;
    wait_rd(3, "stop2");
    record(3, 120, 8'h00, 1, 1);
    chk_bits(11, 24'b11_11111111_0, "stop2");
    chk("stop2 done cycle", done_at, 110);
    chk("stop2 done count", done_cnt, 1);
    chk("stop2 busy cycle 110", {31'b0, bwave[110]}, 32'd1);
    // abort in data bit 3 (cycles 41..50), data source stays non-empty
    do_v[0] = 8'h55; emp_v[0] = 1'b0; en_v[0] = 1'b1;
    wait_rd(0, "abort");
    record(0, 45, 8'h55, 0, 0);
    chk("abort tx before reset", {31'b0, wave[45]}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort tx in reset", {31'b0, tx_v[0]}, 32'd1);
    chk("abort busy in reset", {31'b0, busy_v[0]}, 32'd0);
    chk("abort fifo_rd in reset", {31'b0, rd_v[0]}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_rd(0, "restart");
    record(0, 110, 8'h55, 1, 1);
    chk_bits(10, 24'b1_01010101_0, "restart");
    chk("restart done cycle", done_at, 100);
    chk_high(101, 110, "restart idle high");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
